// File: rtl/divider_pkg.sv
// Purpose: shared types and helpers for the multicycle divider and its step slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

    // Raw state encodings kept as plain constants so older code that compares
    // against bit patterns keeps working alongside the typed enum.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } div_state_t;

    // Iteration counter width for an n-bit quotient: it must count 0..n-1
    // and is sized to also hold n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multicycle_divider_if.sv
// Purpose: operand and result handshake bundle for the multicycle divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: master = requester (drives operands, out_ready); slave = divider.
interface multicycle_divider_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_step.sv
// Purpose: one restoring-division step, producing one quotient bit.
// Latency: combinational.
// Backpressure: none.
// Ports: r (partial remainder, must be < divisor), shift_in (next dividend bit),
//        divisor; r_next (updated remainder), q_bit (quotient bit).
module divider_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] r,
    input  logic         shift_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_next,
    output logic         q_bit
);
    logic [N:0]   t;
    logic [N-1:0] diff_lo;

    assign t = {r, shift_in};
    assign q_bit = (t >= {1'b0, divisor});
    // When the subtraction is taken the true result is < divisor, so it fits
    // in N bits and the low N bits of the difference are exact.
    assign diff_lo = t[N-1:0] - divisor;
    assign r_next  = q_bit ? diff_lo : t[N-1:0];
endmodule

// File: rtl/multicycle_divider.sv
// Purpose: sequential restoring divider, 2N-bit dividend by N-bit divisor -> N-bit quotient/remainder.
// Latency: N+1 cycles accept-to-result (1 cycle for divide-by-zero / overflow); one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then a one-cycle bubble.
// Ports: clk, rst_n (async active-low), bus (slave side of multicycle_divider_if).
module multicycle_divider
    import divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_divider_if.slave   bus
);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    div_state_t       state;
    logic [N-1:0]     r_q;        // partial remainder, always < dvs_q
    logic [N-1:0]     q_q;        // dividend low bits shifting out, quotient bits shifting in
    logic [N-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt;

    logic             out_valid_q;
    logic [N-1:0]     quotient_q;
    logic [N-1:0]     remainder_q;
    logic             dbz_q;
    logic             ovf_q;

    logic [N-1:0]     dvd_hi;
    logic [N-1:0]     dvd_lo;
    logic [N-1:0]     r_next;
    logic             q_bit;
    logic             accept;

    assign dvd_hi = bus.dividend[2*N-1:N];
    assign dvd_lo = bus.dividend[N-1:0];

    assign bus.in_ready    = (state == IDLE);
    assign accept          = bus.in_valid && (state == IDLE);

    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

    divider_step #(.N(N)) u_step (
        .r        (r_q),
        .shift_in (q_q[N-1]),
        .divisor  (dvs_q),
        .r_next   (r_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dvd_lo;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                        end else if (dvd_hi >= bus.divisor) begin
                            // Quotient would need more than N bits.
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                        end else begin
                            state <= CALC;
                            dvs_q <= bus.divisor;
                            r_q   <= dvd_hi;
                            q_q   <= dvd_lo;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    r_q <= r_next;
                    q_q <= {q_q[N-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        // Load the result registers straight from this step so
                        // out_valid rises on the same edge as the last bit.
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= {q_q[N-2:0], q_bit};
                        remainder_q <= r_next;
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_divider.sv
module tb_multicycle_divider;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_divider_if #(.N(N)) dif ();

    multicycle_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one operation, pushes its expected result, waits for it, then
    // optionally stalls the result for 'hold' cycles before consuming it.
    task automatic do_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input logic eov, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        logic busy_ok;
        e.q = eq; e.r = er; e.dbz = edz; e.ovf = eov;
        e.lat = (edz || eov) ? 1 : N + 1;
        sb.push_back(e);

        dif.dividend = dvd;
        dif.divisor  = dvs;
        dif.in_valid = 1'b1;
        check("in_ready_idle", 32'(dif.in_ready), 32'd1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;

        lat = 1;
        busy_ok = 1'b1;
        while (!dif.out_valid && lat < 4 * N) begin
            if (dif.in_ready) busy_ok = 1'b0;
            // Operands wander during CALC; they must not affect the result.
            dif.dividend = (2*N)'($urandom);
            dif.divisor  = N'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready_calc", 32'(busy_ok), 32'd1);
        check("out_valid", 32'(dif.out_valid), 32'd1);
        check("in_ready_done", 32'(dif.in_ready), 32'd0);

        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            got = sb.pop_front();
            check("latency", 32'(lat), 32'(got.lat));
            check("quotient", 32'(dif.quotient), 32'(got.q));
            check("remainder", 32'(dif.remainder), 32'(got.r));
            check("div_by_zero", 32'(dif.div_by_zero), 32'(got.dbz));
            check("overflow", 32'(dif.overflow), 32'(got.ovf));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", 32'(dif.out_valid), 32'd1);
                check("hold_quotient", 32'(dif.quotient), 32'(got.q));
                check("hold_remainder", 32'(dif.remainder), 32'(got.r));
            end
        end

        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        check("consume_valid", 32'(dif.out_valid), 32'd0);
        check("consume_ready", 32'(dif.in_ready), 32'd1);
    endtask

    initial begin
        logic ghost;
        logic [N-1:0]   rdvs;
        logic [2*N-1:0] rdvd;

        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_quotient", 32'(dif.quotient), 32'd0);
        check("rst_remainder", 32'(dif.remainder), 32'd0);
        check("rst_flags", 32'({dif.div_by_zero, dif.overflow}), 32'd0);
        check("rst_in_ready", 32'(dif.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(16'd49,    8'd7,   8'd7,   8'd0,   1'b0, 1'b0, 0);
        do_op(16'd16384, 8'd128, 8'd128, 8'd0,   1'b0, 1'b0, 0);
        do_op(16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 0);
        do_op(16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 0);
        do_op(16'd65535, 8'd255, 8'd255, 8'd0,   1'b0, 1'b1, 0);
        do_op(16'd100,   8'd0,   8'd255, 8'd100, 1'b1, 1'b0, 0);

        // Backpressure: result held for 5 stalled cycles
        do_op(16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 5);

        // Reset mid-CALC, after 4 iterations
        dif.dividend = 16'd1000;
        dif.divisor  = 8'd7;
        dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
        check("midrst_quotient", 32'(dif.quotient), 32'd0);
        check("midrst_remainder", 32'(dif.remainder), 32'd0);
        check("midrst_in_ready", 32'(dif.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ghost = 1'b0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (dif.out_valid) ghost = 1'b1;
        end
        check("midrst_no_result", 32'(ghost), 32'd0);
        do_op(16'd49, 8'd7, 8'd7, 8'd0, 1'b0, 1'b0, 0);

        // Random normal-range operations against a reference division
        for (int i = 0; i < 8; i++) begin
            rdvs = N'($urandom_range(1, (1 << N) - 1));
            rdvd = {N'($urandom_range(0, int'(rdvs) - 1)), N'($urandom)};
            do_op(rdvd, rdvs, N'(rdvd / {8'd0, rdvs}), N'(rdvd % {8'd0, rdvs}),
                  1'b0, 1'b0, i % 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_divider.md
Name: multicycle_divider

Overview:
Sequential unsigned divider, the inverse of the team's single-cycle N×N→2N multiplier. It accepts a 2N-bit dividend and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder. It uses restoring division, one quotient bit per clock, so a product from the multiplier divided by either operand round-trips exactly. A valid/ready handshake sits on both the operand side and the result side.

Parameters:
N, 8, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits, N ≥ 2

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
dividend  input  2N  unsigned dividend
divisor  input  N  unsigned divisor
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
quotient  output  N  unsigned quotient
remainder  output  N  unsigned remainder
div_by_zero  output  1  divisor was 0
overflow  output  1  quotient would not fit in N bits (dividend[2N-1:N] ≥ divisor, divisor ≠ 0)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - in_ready=1 once state is IDLE.
  - Reset during CALC or DONE abandons the operation; no result is emitted.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE), combinational from state only.
- IDLE, accept on the edge with in_valid && in_ready:
  - If divisor==0: go to DONE with div_by_zero=1, overflow=0, quotient='1, remainder=dividend[N-1:0].
  - Else if dividend[2N-1:N] ≥ divisor: go to DONE with overflow=1, div_by_zero=0, quotient='1, remainder=0.
  - Else: latch divisor; set partial remainder R = dividend[2N-1:N] (R < divisor) and shift register Q = dividend[N-1:0]; clear the iteration counter; go to CALC.
- CALC, per edge:
  - T = {R, Q[N-1]} (N+1 bits).
  - If T ≥ divisor: R = T − divisor, new quotient bit 1. Else: R = T[N-1:0], new quotient bit 0.
  - Q shifts left, taking the quotient bit in its LSB.
  - Counter increments; after the N-th iteration edge, state = DONE.
  - R always fits in N bits because R < divisor holds at every step.
- DONE:
  - out_valid=1; quotient=Q, remainder=R; flags=0 on a normal result.
  - Outputs are held stable while out_valid && !out_ready.
  - On the edge with out_ready: out_valid drops, state goes to IDLE.
  - No accept is possible in the same cycle as the out_ready edge; there is a one-cycle bubble.
- Latency:
  - Normal: out_valid is high in the cycle following the N-th edge after the accept edge (accept edge + N edges).
  - Error (div_by_zero or overflow): out_valid is high in the cycle immediately after the accept edge.
  - Throughput: one operation per N+2 cycles with out_ready held at 1.
- Input changes while not in IDLE are ignored; operands are captured only at accept.
- Result invariant when no flag is set: quotient*divisor + remainder == dividend, and remainder < divisor.
- Outputs are registered; quotient, remainder and the flags are undefined-free (0) before the first result.

Decomposition:
- Package divider_pkg:
  - div_state_t enum {IDLE, CALC, DONE}.
  - Iteration counter width localparam expressed as $clog2(N+1).
- Sub-module divider_step, combinational:
  - Inputs R[N-1:0], shift-in bit, divisor.
  - Outputs new R and quotient bit.
  - Reused unchanged by a future unrolled/pipelined divider.
- Top holds the FSM, registers and handshake.

Test Plan:
- Reset then 49/7 (N=8) → after accept + 8 edges: out_valid=1, quotient=7, remainder=0, flags 0; in_ready=0 throughout CALC.
- 16384/128 (multiplier product round-trip) → quotient=128, remainder=0. Separately, 1000/7 → quotient=142, remainder=6.
- Boundary 65279/255 → quotient=255, remainder=254, overflow=0. Then 65535/255 → overflow=1, quotient=255, remainder=0, out_valid one cycle after accept.
- 100/0 → div_by_zero=1, quotient=255, remainder=100, out_valid one cycle after accept.
- Backpressure: 1000/7 with out_ready=0 for 5 cycles after out_valid → quotient/remainder/out_valid held constant; after one out_ready=1 edge, out_valid=0 and in_ready=1. Also changing dividend during CALC does not alter the result.
- rst_n pulsed low mid-CALC (iteration 4) → outputs immediately 0, state IDLE, in_ready=1, no out_valid. A following 49/7 completes correctly.
